// File: rtl/dual_uop_queue_if.sv
// Decode-to-issue handshake bundle: dual enqueue slots, two oldest issue slots, dequeue count and occupancy.
// The master modport is the decode/issue side; the slave modport is the queue.
interface dual_uop_queue_if #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 160
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             flush_i;
  logic             in1_valid_i;
  logic [UOP_W-1:0] in1_uop_i;
  logic             in2_valid_i;
  logic [UOP_W-1:0] in2_uop_i;
  logic             enq_ready_o;
  logic             out1_valid_o;
  logic [UOP_W-1:0] out1_uop_o;
  logic             out2_valid_o;
  logic [UOP_W-1:0] out2_uop_o;
  logic [1:0]       deq_cnt_i;
  logic [PTR_W:0]   count_o;

  modport master (
    output flush_i, in1_valid_i, in1_uop_i, in2_valid_i, in2_uop_i, deq_cnt_i,
    input  enq_ready_o, out1_valid_o, out1_uop_o, out2_valid_o, out2_uop_o, count_o
  );

  modport slave (
    input  flush_i, in1_valid_i, in1_uop_i, in2_valid_i, in2_uop_i, deq_cnt_i,
    output enq_ready_o, out1_valid_o, out1_uop_o, out2_valid_o, out2_uop_o, count_o
  );
endinterface

// File: rtl/dual_uop_queue.sv
// In-order circular uop buffer: up to 2 enq / 2 deq per cycle; enqueued uops visible next cycle.
// Backpressure: enq_ready_o only when a whole pair fits in registered occupancy; same-cycle deq is not credited.
module dual_uop_queue #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 160
) (
  input logic             clk,
  input logic             rst,
  dual_uop_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] ENQ_LIM = (PTR_W+1)'(DEPTH - 2);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W+1:0] cnt_nxt;
  logic [PTR_W-1:0] head_p1, tail_p1, in2_slot;
  logic             enq_rdy, enq_ok;
  logic [1:0]       enq_n, deq_req, deq_n;

  assign enq_rdy  = (cnt_q <= ENQ_LIM);
  assign enq_ok   = enq_rdy && !q.flush_i;
  assign head_p1  = head_q + PTR_W'(1);
  assign tail_p1  = tail_q + PTR_W'(1);
  assign in2_slot = q.in1_valid_i ? tail_p1 : tail_q;

  always_comb begin
    enq_n = 2'd0;
    if (enq_ok) begin
      enq_n = {1'b0, q.in1_valid_i} + {1'b0, q.in2_valid_i};
    end
  end

  // A request of 3 is treated as 2, then clamped to what is actually held.
  always_comb begin
    deq_req = (q.deq_cnt_i == 2'd3) ? 2'd2 : q.deq_cnt_i;
    deq_n   = deq_req;
    if (cnt_q < (PTR_W+1)'(deq_req)) begin
      deq_n = cnt_q[1:0];
    end
  end

  assign cnt_nxt = {1'b0, cnt_q} + (PTR_W+2)'(enq_n) - (PTR_W+2)'(deq_n);

  always_comb begin
    head_d = head_q + PTR_W'(deq_n);
    tail_d = tail_q + PTR_W'(enq_n);
    cnt_d  = cnt_nxt[PTR_W:0];
    if (q.flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately left unreset; valid flags gate everything read out.
  always_ff @(posedge clk) begin
    if (enq_ok && q.in1_valid_i) begin
      mem[tail_q] <= q.in1_uop_i;
    end
    if (enq_ok && q.in2_valid_i) begin
      mem[in2_slot] <= q.in2_uop_i;
    end
  end

  assign q.enq_ready_o  = enq_rdy;
  assign q.out1_valid_o = (cnt_q >= (PTR_W+1)'(1));
  assign q.out2_valid_o = (cnt_q >= (PTR_W+1)'(2));
  assign q.out1_uop_o   = q.out1_valid_o ? mem[head_q]  : '0;
  assign q.out2_uop_o   = q.out2_valid_o ? mem[head_p1] : '0;
  assign q.count_o      = cnt_q;

  // Unsigned compare also catches underflow, which would wrap to a huge value.
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
    cnt_nxt <= (PTR_W+2)'(DEPTH));
endmodule
